// File: rtl/s6_icap_pkg.sv
// s6_icap_pkg: shared types and constants for the Spartan-6 IPROG reboot master.
//   state_t    - sequencer states (IDLE, REQ, GAP)
//   SYNC0..    - ICAP configuration words used by the IPROG sequence
//   SEQ_LEN    - number of words written per reboot sequence
//   bitswap16  - reverses bit order inside each byte (ICAP bit ordering)
package s6_icap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } state_t;

    localparam logic [15:0] DUMMY     = 16'hFFFF;
    localparam logic [15:0] SYNC0     = 16'hAA99;
    localparam logic [15:0] SYNC1     = 16'h5566;
    localparam logic [15:0] WR_GEN1   = 16'h3261;
    localparam logic [15:0] WR_GEN2   = 16'h3281;
    localparam logic [15:0] WR_GEN3   = 16'h32A1;
    localparam logic [15:0] WR_GEN4   = 16'h32C1;
    localparam logic [15:0] WR_CMD    = 16'h30A1;
    localparam logic [15:0] CMD_IPROG = 16'h000E;
    localparam logic [15:0] NOOP      = 16'h2000;

    localparam int unsigned SEQ_LEN = 14;

    function automatic logic [15:0] bitswap16(input logic [15:0] w);
        logic [15:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[i]     = w[7 - i];
            r[8 + i] = w[15 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/s6_iprog_rom.sv
// s6_iprog_rom: combinational IPROG word table.
//   idx           in  4  - word index 0..13
//   boot_addr     in  24 - multiboot flash address (GENERAL1/GENERAL2)
//   fallback_addr in  24 - fallback flash address (GENERAL3/GENERAL4)
//   word          out 16 - configuration word, ICAP-native bit order not applied
module s6_iprog_rom
    import s6_icap_pkg::*;
#(
    parameter logic [7:0] READ_OP = 8'h03
) (
    input  logic [3:0]  idx,
    input  logic [23:0] boot_addr,
    input  logic [23:0] fallback_addr,
    output logic [15:0] word
);

    always_comb begin
        word = NOOP;
        case (idx)
            4'd0:    word = DUMMY;
            4'd1:    word = SYNC0;
            4'd2:    word = SYNC1;
            4'd3:    word = WR_GEN1;
            4'd4:    word = boot_addr[15:0];
            4'd5:    word = WR_GEN2;
            4'd6:    word = {READ_OP, boot_addr[23:16]};
            4'd7:    word = WR_GEN3;
            4'd8:    word = fallback_addr[15:0];
            4'd9:    word = WR_GEN4;
            4'd10:   word = {READ_OP, fallback_addr[23:16]};
            4'd11:   word = WR_CMD;
            4'd12:   word = CMD_IPROG;
            4'd13:   word = NOOP;
            default: word = NOOP;
        endcase
    end

endmodule

// File: rtl/s6_icap_reboot.sv
// s6_icap_reboot: Wishbone master that writes the Spartan-6 IPROG sequence
// (14 words) to the ICAP Wishbone slave after a single start strobe.
//   clk, reset_n            - system clock, async active-low reset
//   start                   - one-cycle request (ignored while busy)
//   boot_addr/fallback_addr - flash addresses, latched on accepted start
//   busy                    - sequence in progress (through the done cycle)
//   done                    - one-cycle pulse at completion or abort
//   error                   - sticky ack timeout, cleared by next start
//   cyc_o/stb_o/we_o/dat_o  - Wishbone write request, dat_o[31:16] = 0
//   ack_i                   - Wishbone ack, only honoured in REQ
module s6_icap_reboot
    import s6_icap_pkg::*;
#(
    parameter int unsigned GAP_CYCLES  = 8,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter logic        BITSWAP     = 1'b1,
    parameter logic [7:0]  READ_OP     = 8'h03
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [23:0] boot_addr,
    input  logic [23:0] fallback_addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] dat_o,
    input  logic        ack_i
);

    localparam int unsigned GW = $clog2(GAP_CYCLES + 2);

    state_t          state;
    logic [3:0]      idx;
    logic [7:0]      tmo_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [23:0]     boot_q;
    logic [23:0]     fb_q;
    logic [3:0]      rom_idx;
    logic [15:0]     rom_word;
    logic [15:0]     next_word;

    // dat_o is registered on entry to REQ, so the ROM looks one word ahead
    // while in GAP. Word 0 is a constant, so the stale latched addresses
    // seen in IDLE never matter.
    always_comb begin
        rom_idx   = (state == GAP) ? idx + 4'd1 : '0;
        next_word = BITSWAP ? bitswap16(rom_word) : rom_word;
    end

    s6_iprog_rom #(
        .READ_OP(READ_OP)
    ) u_rom (
        .idx          (rom_idx),
        .boot_addr    (boot_q),
        .fallback_addr(fb_q),
        .word         (rom_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            tmo_cnt <= '0;
            gap_cnt <= '0;
            boot_q  <= '0;
            fb_q    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            we_o    <= 1'b0;
            dat_o   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // busy drops one cycle after the return to IDLE so it
                    // still covers the done pulse.
                    busy <= start;
                    if (start) begin
                        state   <= REQ;
                        boot_q  <= boot_addr;
                        fb_q    <= fallback_addr;
                        idx     <= '0;
                        tmo_cnt <= '0;
                        error   <= 1'b0;
                        cyc_o   <= 1'b1;
                        stb_o   <= 1'b1;
                        we_o    <= 1'b1;
                        dat_o   <= {16'h0000, next_word};
                    end
                end
                REQ: begin
                    if (ack_i) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                        cyc_o   <= 1'b0;
                        stb_o   <= 1'b0;
                        we_o    <= 1'b0;
                    end else if (tmo_cnt == 8'(ACK_TIMEOUT - 1)) begin
                        state <= IDLE;
                        error <= 1'b1;
                        done  <= 1'b1;
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        we_o  <= 1'b0;
                        dat_o <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES)) begin
                        if (idx == 4'(SEQ_LEN - 1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            dat_o <= '0;
                        end else begin
                            state   <= REQ;
                            idx     <= idx + 4'd1;
                            tmo_cnt <= '0;
                            cyc_o   <= 1'b1;
                            stb_o   <= 1'b1;
                            we_o    <= 1'b1;
                            dat_o   <= {16'h0000, next_word};
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s6_icap_reboot.sv
// tb_s6_icap_reboot: scoreboard bench for s6_icap_reboot (BITSWAP=1).
// Stimulus pushes the expected word list for each sequence; a monitor pops
// and compares on every rising stb_o and checks handshake timing.
module tb_s6_icap_reboot;

    localparam int unsigned GAP = 8;
    localparam int unsigned TMO = 255;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] boot_addr = '0;
    logic [23:0] fallback_addr = '0;
    logic        busy, done, error, cyc_o, stb_o, we_o;
    logic [31:0] dat_o;
    logic        ack_i = 1'b0;

    s6_icap_reboot #(
        .GAP_CYCLES (GAP),
        .ACK_TIMEOUT(TMO),
        .BITSWAP    (1'b1),
        .READ_OP    (8'h03)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .boot_addr    (boot_addr),
        .fallback_addr(fallback_addr),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .cyc_o        (cyc_o),
        .stb_o        (stb_o),
        .we_o         (we_o),
        .dat_o        (dat_o),
        .ack_i        (ack_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic [15:0] w;
        int          idx;
        bit          first;
    } exp_t;

    exp_t        eq[$];
    logic [15:0] obs[14];
    int          words_issued = 0;
    int          done_cnt = 0;
    int          ack_mode = 0;   // 0 never ack, 1 clean ack, 2 noisy (double + spurious)
    int          lat = 5;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r = {r[6:0], b[k]};
        return r;
    endfunction

    function automatic logic [15:0] ref_word(input int i, input logic [23:0] b, input logic [23:0] f);
        logic [15:0] t[14];
        t = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, b[15:0], 16'h3281, {8'h03, b[23:16]},
              16'h32A1, f[15:0], 16'h32C1, {8'h03, f[23:16]}, 16'h30A1, 16'h000E, 16'h2000};
        return {rev8(t[i][15:8]), rev8(t[i][7:0])};
    endfunction

    // Slave model: ack after lat cycles of stb; noisy mode repeats the ack
    // into the gap and throws random acks while stb is low.
    initial begin
        int wcnt = 0;
        bit hold = 0;
        forever begin
            @(negedge clk);
            if (stb_o) begin
                wcnt++;
                ack_i = (ack_mode != 0) && (wcnt >= lat);
                hold  = ack_i && (ack_mode == 2);
            end else begin
                wcnt = 0;
                if (hold) begin
                    ack_i = 1'b1;
                    hold  = 0;
                end else begin
                    ack_i = (ack_mode == 2) && ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    // Monitor: samples 1ns after each rising edge.
    initial begin
        bit          prev_stb = 0;
        int          run_len = 0;
        int          low_len = 0;
        logic [31:0] cur = '0;
        exp_t        e;
        forever begin
            @(posedge clk);
            #1;
            chk("wb controls", {30'b0, cyc_o, we_o}, {30'b0, stb_o, stb_o});
            if (done) done_cnt++;
            if (prev_stb && ack_i) chk("stb drop after ack", 32'(stb_o), 32'(0));
            else if (prev_stb && !stb_o) chk("timeout length", 32'(run_len), 32'(TMO));
            if (stb_o && !prev_stb) begin
                if (eq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected request: dat_o=%h with no word expected", dat_o);
                end else begin
                    e = eq.pop_front();
                    chk($sformatf("word %0d", e.idx), dat_o, {16'h0000, e.w});
                    obs[e.idx] = dat_o[15:0];
                    if (!e.first) chk("gap length", 32'(low_len), 32'(GAP + 1));
                end
                words_issued++;
                run_len = 1;
                low_len = 0;
                cur     = dat_o;
            end else if (stb_o) begin
                run_len++;
                chk("dat_o stable", dat_o, cur);
            end else begin
                low_len++;
            end
            prev_stb = stb_o;
        end
    end

    task automatic run_seq(input logic [23:0] b, input logic [23:0] f, input int mode,
                           input int l, input bit abort, input bit inject);
        int d0;
        bit busy_bad = 0;
        bit saw_done = 0;
        bit injected = 0;
        ack_mode = mode;
        lat      = l;
        @(negedge clk);
        boot_addr     = b;
        fallback_addr = f;
        start         = 1'b1;
        words_issued  = 0;
        d0            = done_cnt;
        if (abort) eq.push_back('{w: ref_word(0, b, f), idx: 0, first: 1'b1});
        else for (int i = 0; i < 14; i++) eq.push_back('{w: ref_word(i, b, f), idx: i, first: (i == 0)});
        @(negedge clk);
        start         = 1'b0;
        boot_addr     = 24'($urandom);
        fallback_addr = 24'($urandom);
        chk("stb after start", 32'(stb_o), 32'(1));
        chk("error cleared on start", 32'(error), 32'(0));
        chk("busy after start", 32'(busy), 32'(1));
        for (int c = 0; c < 6000 && !saw_done; c++) begin
            start = 1'b0;
            if (done) begin
                saw_done = 1;
                chk("busy at done", 32'(busy), 32'(1));
            end else if (!busy) begin
                busy_bad = 1;
            end
            if (inject && !injected && words_issued == 6) begin
                start         = 1'b1;
                boot_addr     = 24'($urandom);
                fallback_addr = 24'($urandom);
                injected      = 1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done seen", 32'(saw_done), 32'(1));
        chk("busy during sequence", 32'(busy_bad), 32'(0));
        chk("busy after done", 32'(busy), 32'(0));
        chk("done is a pulse", 32'(done), 32'(0));
        chk("error at end", 32'(error), 32'(abort));
        chk("done count", 32'(done_cnt - d0), 32'(1));
        chk("queue drained", 32'(eq.size()), 32'(0));
        chk("words issued", 32'(words_issued), abort ? 32'(1) : 32'(14));
    endtask

    initial begin
        int  d0;
        bit  seen;
        bit  reached;
        logic [23:0] rb, rf;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset done", 32'(done), 32'(0));
        chk("reset error", 32'(error), 32'(0));
        chk("reset ctl", {29'b0, cyc_o, stb_o, we_o}, 32'(0));
        chk("reset dat_o", dat_o, 32'(0));
        reset_n = 1'b1;
        @(negedge clk);

        run_seq(24'h0A0000, 24'h000000, 1, 5, 0, 0);
        chk("swapped sync word", 32'(obs[1]), 32'h5599);
        chk("swapped iprog word", 32'(obs[12]), 32'h0070);
        chk("swapped boot high", 32'(obs[6]), 32'hC050);

        for (int unsigned n = 0; n < 3; n++)
            run_seq(24'($urandom), 24'($urandom), 2, int'($urandom_range(1, 6)), 0, 0);

        run_seq(24'($urandom), 24'($urandom), 2, 3, 0, 1);
        run_seq(24'($urandom), 24'($urandom), 0, 1, 1, 0);
        run_seq(24'($urandom), 24'($urandom), 1, 2, 0, 0);

        // Reset while in the gap after word 7.
        ack_mode = 1;
        lat      = 3;
        rb       = 24'($urandom);
        rf       = 24'($urandom);
        @(negedge clk);
        boot_addr     = rb;
        fallback_addr = rf;
        start         = 1'b1;
        words_issued  = 0;
        for (int i = 0; i < 14; i++) eq.push_back('{w: ref_word(i, rb, rf), idx: i, first: (i == 0)});
        @(negedge clk);
        start   = 1'b0;
        reached = 0;
        for (int c = 0; c < 3000 && !reached; c++) begin
            if (words_issued == 8 && !stb_o) reached = 1;
            else @(negedge clk);
        end
        chk("reached gap after word 7", 32'(reached), 32'(1));
        reset_n = 1'b0;
        #1;
        chk("async reset ctl", {29'b0, cyc_o, stb_o, we_o}, 32'(0));
        chk("async reset status", {29'b0, busy, done, error}, 32'(0));
        chk("async reset dat_o", dat_o, 32'(0));
        eq.delete();
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen    = 0;
        repeat (40) begin
            @(negedge clk);
            if (stb_o || busy) seen = 1;
        end
        chk("no resume after reset", 32'(seen), 32'(0));
        chk("no done after reset", 32'(done_cnt - d0), 32'(0));

        run_seq(24'($urandom), 24'($urandom), 2, 4, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
